// File: rtl/select_sequencer.sv
// Select generator for a downstream 3-to-8 one-hot decoder: steps a channel index
// up or down over the enabled channels, holding each index for dwell+1 cycles.
module select_sequencer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               dir,
    input  logic               load,
    input  logic [2:0]         load_val,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         mask,
    output logic [2:0]         S,
    output logic               active,
    output logic               step,
    output logic               wrap
);

    localparam logic [DWELL_W-1:0] CNT_ZERO = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

    logic [2:0]         s_q, s_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               step_q, step_d;
    logic               wrap_q, wrap_d;
    logic [2:0]         nxt_s;

    // First enabled channel after cur in the chosen direction; the 8th candidate is cur itself.
    function automatic logic [2:0] next_index(input logic [2:0] cur, input logic dn,
                                              input logic [7:0] m);
        logic [2:0] cand;
        logic       found;
        logic [3:0] k4;
        next_index = cur;
        found      = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            k4   = 4'(k);
            cand = dn ? (cur - k4[2:0]) : (cur + k4[2:0]);
            if (!found && m[cand]) begin
                next_index = cand;
                found      = 1'b1;
            end else begin
                found      = found;
            end
        end
    endfunction

    // Next-state selection: load beats disable, disable beats empty mask, then count/advance.
    always_comb begin
        s_d    = s_q;
        cnt_d  = cnt_q;
        step_d = 1'b0;
        wrap_d = 1'b0;
        nxt_s  = next_index(s_q, dir, mask);
        if (load) begin
            s_d   = load_val;
            cnt_d = CNT_ZERO;
        end else if (!en) begin
            cnt_d = cnt_q;
        end else if (mask == 8'h00) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q < dwell) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            // >= rather than == so a dwell lowered below the count advances at once
            cnt_d  = CNT_ZERO;
            s_d    = nxt_s;
            step_d = 1'b1;
            wrap_d = dir ? (nxt_s >= s_q) : (nxt_s <= s_q);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q    <= 3'd0;
            cnt_q  <= CNT_ZERO;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cnt_q  <= cnt_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    assign S      = s_q;
    assign step   = step_q;
    assign wrap   = wrap_q;
    assign active = en & (mask != 8'h00) & mask[s_q];

endmodule

// File: tb/tb_select_sequencer.sv
// Directed self-checking bench for select_sequencer with hand-computed expectations.
module tb_select_sequencer;

    logic       clk;
    logic       rst;
    logic       en;
    logic       dir;
    logic       load;
    logic [2:0] load_val;
    logic [3:0] dwell;
    logic [7:0] mask;
    logic [2:0] S;
    logic       active;
    logic       step;
    logic       wrap;

    int checks   = 0;
    int failures = 0;

    select_sequencer #(.DWELL_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
        .dwell(dwell), .mask(mask), .S(S), .active(active), .step(step), .wrap(wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] es, input logic est,
                           input logic ew);
        chk({tag, ".S"}, {5'd0, S}, {5'd0, es});
        chk({tag, ".step"}, {7'd0, step}, {7'd0, est});
        chk({tag, ".wrap"}, {7'd0, wrap}, {7'd0, ew});
    endtask

    initial begin
        logic [2:0] exp_s;
        rst = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = 3'd0;
        dwell = 4'd0; mask = 8'h00;
        #2;
        chk_out("reset", 3'd0, 1'b0, 1'b0);

        // Test 1: dwell=0, full mask, counting up
        en = 1'b1; mask = 8'hFF;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t1.active", {7'd0, active}, 8'd1);
        for (int i = 1; i <= 9; i++) begin
            tick();
            exp_s = 3'(i);
            chk_out("t1", exp_s, 1'b1, (exp_s == 3'd0));
        end

        // Test 2: dwell=2 from reset, then lower dwell mid-count
        dwell = 4'd2; rst = 1'b1;
        #1;
        rst = 1'b0;
        tick(); chk_out("t2.e1", 3'd0, 1'b0, 1'b0);
        tick(); chk_out("t2.e2", 3'd0, 1'b0, 1'b0);
        tick(); chk_out("t2.e3", 3'd1, 1'b1, 1'b0);
        tick(); chk_out("t2.e4", 3'd1, 1'b0, 1'b0);
        tick(); chk_out("t2.e5", 3'd1, 1'b0, 1'b0);
        tick(); chk_out("t2.e6", 3'd2, 1'b1, 1'b0);
        dwell = 4'd5;
        tick(); tick(); tick();
        chk_out("t2.cnt3", 3'd2, 1'b0, 1'b0);
        dwell = 4'd1;
        tick(); chk_out("t2.lower", 3'd3, 1'b1, 1'b0);

        // Test 3: sparse mask {1,4,7}
        load = 1'b1; load_val = 3'd0; mask = 8'b1001_0010; dwell = 4'd0; dir = 1'b0;
        tick(); chk_out("t3.load", 3'd0, 1'b0, 1'b0);
        load = 1'b0;
        tick(); chk_out("t3.a", 3'd1, 1'b1, 1'b0); chk("t3.a.act", {7'd0, active}, 8'd1);
        tick(); chk_out("t3.b", 3'd4, 1'b1, 1'b0); chk("t3.b.act", {7'd0, active}, 8'd1);
        tick(); chk_out("t3.c", 3'd7, 1'b1, 1'b0); chk("t3.c.act", {7'd0, active}, 8'd1);
        tick(); chk_out("t3.d", 3'd1, 1'b1, 1'b1); chk("t3.d.act", {7'd0, active}, 8'd1);
        tick(); chk_out("t3.e", 3'd4, 1'b1, 1'b0); chk("t3.e.act", {7'd0, active}, 8'd1);

        // Test 4: counting down, then empty mask
        load = 1'b1; load_val = 3'd2; mask = 8'hFF; dir = 1'b1;
        tick(); chk_out("t4.load", 3'd2, 1'b0, 1'b0);
        load = 1'b0;
        tick(); chk_out("t4.a", 3'd1, 1'b1, 1'b0);
        tick(); chk_out("t4.b", 3'd0, 1'b1, 1'b0);
        tick(); chk_out("t4.c", 3'd7, 1'b1, 1'b1);
        tick(); chk_out("t4.d", 3'd6, 1'b1, 1'b0);
        mask = 8'h00;
        #1;
        chk("t4.mask0.act", {7'd0, active}, 8'd0);
        tick(); chk_out("t4.hold1", 3'd6, 1'b0, 1'b0);
        tick(); chk_out("t4.hold2", 3'd6, 1'b0, 1'b0);

        // Test 5: freeze with en=0, load while disabled
        mask = 8'hFF; dir = 1'b0; dwell = 4'd3;
        tick(); tick();
        chk_out("t5.cnt2", 3'd6, 1'b0, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("t5.frozen", 3'd6, 1'b0, 1'b0);
        end
        en = 1'b1;
        tick(); chk_out("t5.res3", 3'd6, 1'b0, 1'b0);
        tick(); chk_out("t5.resadv", 3'd7, 1'b1, 1'b0);
        en = 1'b0; load = 1'b1; load_val = 3'd5;
        tick(); chk_out("t5.load", 3'd5, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        tick(); tick(); tick();
        chk_out("t5.cnt3", 3'd5, 1'b0, 1'b0);
        tick(); chk_out("t5.adv", 3'd6, 1'b1, 1'b0);

        // Test 6: single-channel mask, then asynchronous reset between edges
        load = 1'b1; load_val = 3'd3; mask = 8'b0000_1000; dwell = 4'd1;
        tick(); chk_out("t6.load", 3'd3, 1'b0, 1'b0);
        load = 1'b0;
        tick(); chk_out("t6.e1", 3'd3, 1'b0, 1'b0);
        tick(); chk_out("t6.e2", 3'd3, 1'b1, 1'b1);
        tick(); chk_out("t6.e3", 3'd3, 1'b0, 1'b0);
        tick(); chk_out("t6.e4", 3'd3, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_out("t6.async", 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
